prt_ingress_writer: RTL and testbench
=====================================

PRT_INGRESS_WRITER -- requirements
Module: prt_ingress_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the byte-lane width of rx_data and prt_wr_data.
REQ-002 Parameter MAX_FRAME_BYTES, default 2000, is the largest frame length accepted into a slot.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 rx_valid / rx_ready / rx_last  input / output / input  1 each  upstream byte stream; a beat transfers when rx_valid && rx_ready.
REQ-006 rx_data  input  DATA_WIDTH  upstream byte.
REQ-007 prt_start_en / prt_start_rdy  output / input  1  PRT start-writing handshake.
REQ-008 prt_slot  input  1  slot chosen by the PRT.
REQ-009 prt_wr_en / prt_wr_rdy  output / input  1  PRT byte-write handshake.
REQ-010 prt_wr_data  output  DATA_WIDTH  byte to the PRT.
REQ-011 prt_finish_en / prt_finish_rdy  output / input  1  PRT finish-writing handshake.
REQ-012 prt_inval_en / prt_inval_rdy / prt_inval_slot  output / input / output  1  PRT invalidate handshake.
REQ-013 desc_valid / desc_ready  output / input  1  downstream frame-descriptor handshake.
REQ-014 desc_slot  output  1  slot holding the frame.
REQ-015 desc_len  output  16  frame length in bytes.
REQ-016 drop_cnt  output  16  count of oversize frames dropped.

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT_WR, STREAM, DESC, OVF_INVAL and DROP.
REQ-018 IDLE: rx_ready=0; when rx_valid && prt_start_rdy, drive prt_start_en=1 for exactly one cycle and go to START.
REQ-019 START: go to WAIT_WR next cycle.
REQ-020 WAIT_WR: when prt_wr_rdy=1, latch prt_slot into slot_q, clear the byte counter and go to STREAM.
REQ-021 STREAM: rx_ready=prt_wr_rdy; prt_wr_en=rx_valid&&rx_ready; prt_wr_data=rx_data (combinational, zero added latency); each accepted beat increments the byte counter.
REQ-022 On an accepted beat with rx_last=1, prt_finish_en SHALL be 1 in the same cycle, desc_len SHALL be loaded with counter+1, and the FSM SHALL go to DESC.
REQ-023 DESC: hold desc_valid=1 with stable desc_slot and desc_len until desc_ready=1, then return to IDLE; rx_ready=0 throughout.
REQ-024 Oversize (feature of REQ-033): an accepted beat that would be byte MAX_FRAME_BYTES+1 with rx_last=0 SHALL NOT be written; instead prt_finish_en=1 that cycle and the FSM goes to OVF_INVAL.
REQ-025 An accepted beat that is byte MAX_FRAME_BYTES+1 with rx_last=1 SHALL also follow REQ-024, except that the FSM then goes to IDLE (not DROP) after OVF_INVAL.
REQ-026 OVF_INVAL: assert prt_inval_en=1 with prt_inval_slot=slot_q in the first cycle prt_inval_rdy=1, increment drop_cnt (saturating at 16'hFFFF), then go to DROP.
REQ-027 DROP: rx_ready=1; discard beats; on an accepted beat with rx_last=1, return to IDLE; no descriptor is emitted for a dropped frame.
REQ-028 The byte counter SHALL be 16 bits and SHALL saturate at 16'hFFFF.
REQ-029 All prt_*_en outputs SHALL be 0 in every state/cycle other than those named above.

Reset
REQ-030 RST_N low SHALL force state=IDLE and slot_q, byte counter, desc_len, desc_slot and drop_cnt to 0.
REQ-031 RST_N low SHALL force rx_ready, desc_valid and all prt_*_en outputs to 0 immediately, without waiting for a clock edge.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; no finish or invalidate is issued afterwards.

Configuration
REQ-033 Macro PRT_INGRESS_LEN_CHECK_EN defined: REQ-024..REQ-027 are active.
REQ-034 Macro undefined: there is no length limit, OVF_INVAL and DROP are unreachable, desc_len saturates per REQ-028, and drop_cnt is tied to 0.

Verification
REQ-035 Bench: 64-byte frame, prt_slot=1, desc_ready=1 -> 64 prt_wr_en pulses, prt_finish_en on byte 64, desc_slot=1, desc_len=64.
REQ-036 Bench: 1-byte frame (rx_last on the first beat) -> prt_wr_en and prt_finish_en in the same cycle, desc_len=1.
REQ-037 Bench: prt_wr_rdy toggled 0/1 every cycle during a 10-byte frame -> rx_ready mirrors prt_wr_rdy, bytes arrive in order, desc_len=10.
REQ-038 Bench: prt_start_rdy=0 while rx_valid=1 -> rx_ready=0 and no prt_start_en until prt_start_rdy rises.
REQ-039 Bench: with macro, MAX_FRAME_BYTES=16, 20-byte frame -> 16 writes, prt_finish_en, prt_inval_en with prt_inval_slot=slot_q, 4 bytes dropped, drop_cnt=1, no desc_valid.
REQ-040 Bench: RST_N pulsed low during STREAM -> outputs are 0 immediately, and the next frame completes normally.

Source files
------------

// File: rtl/prt_ingress_writer.sv
// prt_ingress_writer: moves one upstream byte-stream frame into a PRT slot and
// then hands a frame descriptor (slot, length) downstream.
// Optional feature: define PRT_INGRESS_LEN_CHECK_EN to enable the per-frame
// length limit (MAX_FRAME_BYTES). Oversize frames are finished, invalidated,
// drained and counted in drop_cnt. Without the macro there is no length limit
// and drop_cnt is tied to zero.
module prt_ingress_writer #(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_FRAME_BYTES = 2000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  rx_last,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  prt_start_en,
  input  logic                  prt_start_rdy,
  input  logic                  prt_slot,
  output logic                  prt_wr_en,
  input  logic                  prt_wr_rdy,
  output logic [DATA_WIDTH-1:0] prt_wr_data,
  output logic                  prt_finish_en,
  input  logic                  prt_finish_rdy,
  output logic                  prt_inval_en,
  input  logic                  prt_inval_rdy,
  output logic                  prt_inval_slot,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic                  desc_slot,
  output logic [15:0]           desc_len,
  output logic [15:0]           drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_WR, STREAM, DESC, OVF_INVAL, DROP
  } state_t;

  // The byte counter must be able to reach MAX_FRAME_BYTES for the limit compare.
  if (MAX_FRAME_BYTES < 1 || MAX_FRAME_BYTES > 65535) begin : g_bad_max
    $error("prt_ingress_writer: MAX_FRAME_BYTES must be in 1..65535");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic        slot_q;
  logic [15:0] byte_cnt_q;
  logic [15:0] desc_len_q;
  logic        desc_slot_q;
  logic        ovf_last_q;
  logic        beat_acc;
  logic        ovf_beat;
  logic        rx_ready_c, start_c, wr_c, fin_c, inval_c;

  // The PRT takes the finish together with the last write; its ready is not consulted.
  logic unused_finish_rdy;
  assign unused_finish_rdy = prt_finish_rdy;

  assign beat_acc = rx_valid && prt_wr_rdy;

`ifdef PRT_INGRESS_LEN_CHECK_EN
  logic [15:0] drop_cnt_q;
  // An accepted beat when MAX_FRAME_BYTES are already stored would overflow the slot.
  assign ovf_beat = (byte_cnt_q == 16'(MAX_FRAME_BYTES));

  // Count frames that were invalidated for being oversize.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       drop_cnt_q <= '0;
    else if (inval_c) drop_cnt_q <= sat_inc16(drop_cnt_q);
  end
  assign drop_cnt = drop_cnt_q;
`else
  assign ovf_beat = 1'b0;
  assign drop_cnt = '0;
`endif

  // Next-state and handshake decode for the frame-writing sequence.
  always_comb begin
    state_d    = state_q;
    rx_ready_c = 1'b0;
    start_c    = 1'b0;
    wr_c       = 1'b0;
    fin_c      = 1'b0;
    inval_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid && prt_start_rdy) begin
          start_c = 1'b1;
          state_d = START;
        end
      end
      START:   state_d = WAIT_WR;
      WAIT_WR: if (prt_wr_rdy) state_d = STREAM;
      STREAM: begin
        rx_ready_c = prt_wr_rdy;
        if (beat_acc) begin
          if (ovf_beat) begin
            fin_c   = 1'b1;
            state_d = OVF_INVAL;
          end else begin
            wr_c = 1'b1;
            if (rx_last) begin
              fin_c   = 1'b1;
              state_d = DESC;
            end
          end
        end
      end
      DESC: if (desc_ready) state_d = IDLE;
      OVF_INVAL: begin
        if (prt_inval_rdy) begin
          inval_c = 1'b1;
          state_d = ovf_last_q ? IDLE : DROP;
        end
      end
      DROP: begin
        rx_ready_c = 1'b1;
        if (rx_valid && rx_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, slot, counter and descriptor registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      slot_q      <= 1'b0;
      byte_cnt_q  <= '0;
      desc_len_q  <= '0;
      desc_slot_q <= 1'b0;
      ovf_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT_WR && prt_wr_rdy) begin
        slot_q     <= prt_slot;
        byte_cnt_q <= '0;
      end
      if (wr_c) byte_cnt_q <= sat_inc16(byte_cnt_q);
      if (wr_c && rx_last) begin
        desc_len_q  <= sat_inc16(byte_cnt_q);
        desc_slot_q <= slot_q;
      end
      if (state_q == STREAM && beat_acc && ovf_beat) ovf_last_q <= rx_last;
    end
  end

  // Handshake outputs drop as soon as reset asserts, independent of the clock.
  assign rx_ready       = RST_N & rx_ready_c;
  assign prt_start_en   = RST_N & start_c;
  assign prt_wr_en      = RST_N & wr_c;
  assign prt_finish_en  = RST_N & fin_c;
  assign prt_inval_en   = RST_N & inval_c;
  assign desc_valid     = RST_N & (state_q == DESC);
  assign prt_wr_data    = rx_data;
  assign prt_inval_slot = slot_q;
  assign desc_slot      = desc_slot_q;
  assign desc_len       = desc_len_q;

endmodule

// File: tb/tb_prt_ingress_writer.sv
// Self-checking bench for prt_ingress_writer. Expected write bytes are queued
// as they are presented and popped when prt_wr_en fires; expected descriptor
// contents come from the frame length the bench chose.
module tb_prt_ingress_writer;

`ifdef PRT_INGRESS_LEN_CHECK_EN
  localparam int MAXB = 16;
  localparam int LIM  = 16;
`else
  localparam int MAXB = 2000;
  localparam int LIM  = 1 << 30;
`endif
  localparam int MAIN_LEN = (MAXB < 64) ? MAXB : 64;

  logic        CLK, RST_N;
  logic        rx_valid, rx_ready, rx_last;
  logic [7:0]  rx_data;
  logic        prt_start_en, prt_start_rdy, prt_slot;
  logic        prt_wr_en, prt_wr_rdy;
  logic [7:0]  prt_wr_data;
  logic        prt_finish_en, prt_finish_rdy;
  logic        prt_inval_en, prt_inval_rdy, prt_inval_slot;
  logic        desc_valid, desc_ready, desc_slot;
  logic [15:0] desc_len, drop_cnt;

  prt_ingress_writer #(.DATA_WIDTH(8), .MAX_FRAME_BYTES(MAXB)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_last(rx_last), .rx_data(rx_data),
    .prt_start_en(prt_start_en), .prt_start_rdy(prt_start_rdy), .prt_slot(prt_slot),
    .prt_wr_en(prt_wr_en), .prt_wr_rdy(prt_wr_rdy), .prt_wr_data(prt_wr_data),
    .prt_finish_en(prt_finish_en), .prt_finish_rdy(prt_finish_rdy),
    .prt_inval_en(prt_inval_en), .prt_inval_rdy(prt_inval_rdy), .prt_inval_slot(prt_inval_slot),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_slot(desc_slot),
    .desc_len(desc_len), .drop_cnt(drop_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int seed = 0;
  logic [7:0] exp_q[$];

  // Per-frame observations
  int n_start, n_wr, n_fin, fin_wr, fin_with_wr, n_inval, n_desc, n_acc, n_drop_acc, mirror_err;
  logic inval_slot_seen, got_slot;
  logic [15:0] got_len;
  bit aborted;

  function automatic logic [7:0] byte_of(input int i);
    return 8'((i * 37 + seed * 11 + 5) & 255);
  endfunction

  task automatic present(input int idx, input int len);
    rx_valid = 1'b1;
    rx_data  = byte_of(idx);
    rx_last  = (idx == len - 1);
    if (idx < LIM) exp_q.push_back(byte_of(idx));
  endtask

  task automatic drive_frame(input int len, input bit slot, input bit toggle, input int abort_at);
    int idx, cycles, tail;
    bit done_rx, accepted;
    logic [7:0] b;
    n_start = 0; n_wr = 0; n_fin = 0; fin_wr = -1; fin_with_wr = 0; n_inval = 0;
    n_desc = 0; n_acc = 0; n_drop_acc = 0; mirror_err = 0; aborted = 0;
    inval_slot_seen = 1'b0; got_slot = 1'b0; got_len = '0;
    idx = 0; cycles = 0; tail = 0; done_rx = 0;
    seed++;
    prt_slot = slot; prt_start_rdy = 1'b1; prt_inval_rdy = 1'b1;
    desc_ready = 1'b1; prt_wr_rdy = 1'b1;
    present(idx, len);
    while (tail < 4 && cycles < len * 3 + 20) begin
      @(negedge CLK);
      if (prt_start_en) n_start++;
      if (prt_inval_en) begin n_inval++; inval_slot_seen = prt_inval_slot; end
      if (prt_finish_en) begin
        n_fin++;
        fin_wr = n_wr + (prt_wr_en ? 1 : 0);
        if (prt_wr_en) fin_with_wr++;
      end
      if (desc_valid && desc_ready) begin n_desc++; got_len = desc_len; got_slot = desc_slot; end
      if (toggle && n_acc > 0 && !done_rx && rx_ready !== prt_wr_rdy) mirror_err++;
      accepted = rx_valid && rx_ready;
      if (prt_wr_en) begin
        n_wr++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wr_extra: got byte %0h with no byte expected", prt_wr_data);
        end else begin
          b = exp_q.pop_front();
          if (prt_wr_data !== b) begin
            failures++;
            $display("FAIL wr_data: write %0d got %0h expected %0h", n_wr, prt_wr_data, b);
          end
        end
      end
      if (accepted) begin n_acc++; if (!prt_wr_en) n_drop_acc++; end
      if (abort_at > 0 && n_wr == abort_at) begin
        #1 RST_N = 1'b0;
        aborted = 1;
        break;
      end
      @(posedge CLK); #1;
      cycles++;
      if (done_rx) tail++;
      else if (accepted) begin
        if (rx_last) begin done_rx = 1; rx_valid = 1'b0; rx_last = 1'b0; end
        else begin idx++; present(idx, len); end
      end
      if (toggle) prt_wr_rdy = ~prt_wr_rdy;
    end
    if (!aborted) begin
      rx_valid = 1'b0;
      checks++;
      if (!done_rx) begin
        failures++;
        $display("FAIL frame_timeout: len %0d accepted %0d beats, required %0d", len, n_acc, len);
      end
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; rx_valid = 1'b1; rx_last = 1'b0; rx_data = 8'h00;
    prt_start_rdy = 1'b1; prt_slot = 1'b1; prt_wr_rdy = 1'b1; prt_finish_rdy = 1'b1;
    prt_inval_rdy = 1'b1; desc_ready = 1'b1;
    #2;
    checks++;
    if ({rx_ready, prt_start_en, prt_wr_en, prt_finish_en, prt_inval_en, desc_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 000000",
               {rx_ready, prt_start_en, prt_wr_en, prt_finish_en, prt_inval_en, desc_valid});
    end
    checks++;
    if (desc_len !== 16'd0 || desc_slot !== 1'b0 || drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_regs: desc_len %0d desc_slot %0d drop_cnt %0d required 0 0 0",
               desc_len, desc_slot, drop_cnt);
    end
    rx_valid = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (rx_ready !== 1'b0 || prt_start_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: rx_ready %0d start_en %0d required 0 0", rx_ready, prt_start_en);
    end
    @(posedge CLK); #1;
  endtask

  task automatic check_good_frame(input string name, input int len, input bit slot);
    checks++;
    if (n_wr != len) begin failures++; $display("FAIL %s_writes: got %0d required %0d", name, n_wr, len); end
    checks++;
    if (n_fin != 1 || fin_wr != len) begin
      failures++;
      $display("FAIL %s_finish: count %0d at write %0d required 1 at %0d", name, n_fin, fin_wr, len);
    end
    checks++;
    if (n_desc != 1 || got_len !== 16'(len) || got_slot !== slot) begin
      failures++;
      $display("FAIL %s_desc: count %0d len %0d slot %0d required 1 %0d %0d", name, n_desc, got_len, got_slot, len, slot);
    end
    checks++;
    if (n_start != 1 || n_inval != 0) begin
      failures++;
      $display("FAIL %s_ctrl: start %0d inval %0d required 1 0", name, n_start, n_inval);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL %s_missing: %0d bytes never written, required 0", name, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_frame_main;
    drive_frame(MAIN_LEN, 1'b1, 1'b0, 0);
    check_good_frame("main", MAIN_LEN, 1'b1);
  endtask

  task automatic test_one_byte;
    drive_frame(1, 1'b0, 1'b0, 0);
    check_good_frame("one_byte", 1, 1'b0);
    checks++;
    if (fin_with_wr != 1) begin failures++; $display("FAIL one_byte_same_cycle: got %0d required 1", fin_with_wr); end
  endtask

  task automatic test_start_stall;
    int bad;
    bad = 0;
    rx_valid = 1'b1; rx_data = 8'h5A; rx_last = 1'b0; prt_start_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (rx_ready !== 1'b0 || prt_start_en !== 1'b0) bad++;
      @(posedge CLK); #1;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL start_stall: %0d busy cycles, required 0", bad); end
    drive_frame(4, 1'b1, 1'b0, 0);
    check_good_frame("after_stall", 4, 1'b1);
  endtask

  task automatic test_wr_toggle;
    drive_frame(10, 1'b0, 1'b1, 0);
    check_good_frame("toggle", 10, 1'b0);
    checks++;
    if (mirror_err != 0) begin failures++; $display("FAIL toggle_mirror: got %0d mismatched cycles required 0", mirror_err); end
  endtask

`ifdef PRT_INGRESS_LEN_CHECK_EN
  task automatic test_oversize;
    drive_frame(20, 1'b1, 1'b0, 0);
    checks++;
    if (n_wr != 16 || n_fin != 1 || fin_wr != 16) begin
      failures++;
      $display("FAIL ovf_writes: wr %0d fin %0d at %0d required 16 1 16", n_wr, n_fin, fin_wr);
    end
    checks++;
    if (n_inval != 1 || inval_slot_seen !== 1'b1) begin
      failures++;
      $display("FAIL ovf_inval: count %0d slot %0d required 1 1", n_inval, inval_slot_seen);
    end
    checks++;
    if (n_drop_acc != 4 || n_desc != 0 || drop_cnt !== 16'd1) begin
      failures++;
      $display("FAIL ovf_drop: dropped %0d desc %0d drop_cnt %0d required 4 0 1", n_drop_acc, n_desc, drop_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_missing: %0d bytes unwritten required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_oversize_last;
    drive_frame(17, 1'b0, 1'b0, 0);
    checks++;
    if (n_wr != 16 || n_inval != 1 || inval_slot_seen !== 1'b0 || n_desc != 0 || drop_cnt !== 16'd2) begin
      failures++;
      $display("FAIL ovf_last: wr %0d inval %0d slot %0d desc %0d drop_cnt %0d required 16 1 0 0 2",
               n_wr, n_inval, inval_slot_seen, n_desc, drop_cnt);
    end
    exp_q.delete();
    drive_frame(3, 1'b1, 1'b0, 0);
    check_good_frame("after_ovf_last", 3, 1'b1);
  endtask
`else
  task automatic test_no_limit;
    drive_frame(2100, 1'b1, 1'b0, 0);
    check_good_frame("no_limit", 2100, 1'b1);
    checks++;
    if (drop_cnt !== 16'd0) begin failures++; $display("FAIL no_limit_drop: got %0d required 0", drop_cnt); end
  endtask
`endif

  task automatic test_reset_mid;
    int stray;
    stray = 0;
    drive_frame(30, 1'b1, 1'b0, 8);
    #1;
    checks++;
    if (!aborted || {rx_ready, prt_start_en, prt_wr_en, prt_finish_en, prt_inval_en, desc_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: aborted %0d got %b required 000000", aborted,
               {rx_ready, prt_start_en, prt_wr_en, prt_finish_en, prt_inval_en, desc_valid});
    end
    checks++;
    if (desc_len !== 16'd0 || drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_regs: desc_len %0d drop_cnt %0d required 0 0", desc_len, drop_cnt);
    end
    rx_valid = 1'b0; rx_last = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (prt_finish_en || prt_inval_en || desc_valid || prt_wr_en) stray++;
      @(posedge CLK); #1;
    end
    checks++;
    if (stray != 0) begin failures++; $display("FAIL reset_mid_stray: got %0d events required 0", stray); end
    exp_q.delete();
    drive_frame(5, 1'b0, 1'b0, 0);
    check_good_frame("after_reset", 5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame_main();
    test_one_byte();
    test_start_stall();
    test_wr_toggle();
`ifdef PRT_INGRESS_LEN_CHECK_EN
    test_oversize();
    test_oversize_last();
`else
    test_no_limit();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
